// File: rtl/fft_dma_burst_scheduler_pkg.sv
// Shared definitions for the DMA burst scheduler slice.
// The state encoding, the 4 KB AXI boundary constant and a request record
// type are used by the scheduler RTL and by anything that models its
// request stream.
package fft_dma_pkg;

    localparam int unsigned BOUNDARY_BYTES = 4096;
    localparam int unsigned DMA_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

    typedef struct packed {
        logic [DMA_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
    } dma_burst_req_t;

endpackage

// File: rtl/fft_dma_burst_scheduler_if.sv
// Burst request channel between the scheduler and an AXI read/write master.
//   req_valid/req_ready : request handshake (scheduler -> master)
//   req_addr/req_len    : burst start byte address and AXI LEN (beats-1)
//   burst_done          : one-cycle pulse per fully completed burst
// modport master : the scheduler side (issues requests)
// modport slave  : the AXI master engine side (accepts and completes them)
interface fft_dma_burst_scheduler_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic [AXI_ADDR_WIDTH-1:0] req_addr;
    logic [7:0]                req_len;
    logic                      burst_done;

    modport master (
        output req_valid,
        output req_addr,
        output req_len,
        input  req_ready,
        input  burst_done
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_len,
        output req_ready,
        output burst_done
    );
endinterface

// File: rtl/fft_dma_burst_scheduler_len_calc.sv
// Combinational burst sizer shared by the read and write scheduler instances.
//   remaining : beats still to be issued for the transfer
//   cur_addr  : low 12 bits of the next burst start byte address
//   beats     : min(remaining, MAX_BURST, beats left before the 4 KB boundary)
// A zero remaining count yields zero beats; callers never issue in that case.
module fft_burst_len_calc
    import fft_dma_pkg::*;
#(
    parameter int unsigned TOP_LEN_WIDTH = 32,
    parameter int unsigned BEAT_BYTES    = 8,
    parameter int unsigned MAX_BURST     = 256
) (
    input  logic [TOP_LEN_WIDTH-1:0] remaining,
    input  logic [11:0]              cur_addr,
    output logic [8:0]               beats
);
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

    logic [12:0] bytes_to_bnd;
    logic [12:0] beats_to_bnd;
    logic [8:0]  cap;

    always_comb begin
        // 13 bits so that an aligned address (offset 0) yields a full 4096
        bytes_to_bnd = 13'(BOUNDARY_BYTES) - {1'b0, cur_addr};
        beats_to_bnd = bytes_to_bnd >> BEAT_SHIFT;

        if (remaining < TOP_LEN_WIDTH'(MAX_BURST)) begin
            cap = 9'(remaining);
        end else begin
            cap = 9'(MAX_BURST);
        end

        if ({4'b0, cap} < beats_to_bnd) begin
            beats = cap;
        end else begin
            beats = 9'(beats_to_bnd);
        end
    end
endmodule

// File: rtl/fft_dma_burst_scheduler.sv
// Splits one DMA transfer (start byte address + length in beats) into
// AXI-legal bursts, issues them over a valid/ready request channel, tracks
// outstanding bursts and pulses done once every burst has completed.
//   clk, rst_n           : clock, asynchronous active-low reset
//   top_valid/addr/len   : load the shadow transfer registers (IDLE only)
//   start                : begin the transfer held in the shadow registers
//   req_if (master)      : burst request channel plus burst_done completions
//   busy                 : transfer in progress (ISSUE or DRAIN)
//   done                 : one-cycle pulse when the transfer completes
module fft_dma_burst_scheduler
    import fft_dma_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned TOP_LEN_WIDTH   = 32,
    parameter int unsigned BEAT_BYTES      = 8,
    parameter int unsigned MAX_BURST       = 256,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      top_valid,
    input  logic [AXI_ADDR_WIDTH-1:0] top_addr,
    input  logic [TOP_LEN_WIDTH-1:0]  top_len,
    input  logic                      start,
    fft_dma_burst_scheduler_if.master req_if,
    output logic                      busy,
    output logic                      done
);
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] shadow_addr_q, shadow_addr_d;
    logic [TOP_LEN_WIDTH-1:0]  shadow_len_q, shadow_len_d;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [TOP_LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [OUT_W-1:0]          outstanding_q, outstanding_d;
    logic                      req_valid_q, req_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [7:0]                req_len_q, req_len_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [TOP_LEN_WIDTH-1:0]  calc_rem;
    logic [11:0]               calc_off;
    logic [8:0]                calc_beats;
    logic                      accept;
    logic                      completion;
    logic [8:0]                beats_issued;

    // In IDLE the sizer looks at the shadow registers so the first request
    // can be registered in the same cycle start is seen.
    assign calc_rem = (state_q == IDLE) ? shadow_len_q : remaining_q;
    assign calc_off = (state_q == IDLE) ? shadow_addr_q[11:0] : cur_addr_q[11:0];

    fft_burst_len_calc #(
        .TOP_LEN_WIDTH (TOP_LEN_WIDTH),
        .BEAT_BYTES    (BEAT_BYTES),
        .MAX_BURST     (MAX_BURST)
    ) u_len_calc (
        .remaining (calc_rem),
        .cur_addr  (calc_off),
        .beats     (calc_beats)
    );

    assign accept       = req_valid_q && req_if.req_ready;
    // A completion with nothing outstanding is dropped (counter saturates at 0)
    assign completion   = req_if.burst_done && (outstanding_q != '0);
    assign beats_issued = {1'b0, req_len_q} + 9'd1;

    always_comb begin
        state_d       = state_q;
        shadow_addr_d = shadow_addr_q;
        shadow_len_d  = shadow_len_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        req_len_d     = req_len_q;
        outstanding_d = outstanding_q;

        if (accept && !completion) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!accept && completion) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (top_valid) begin
                    shadow_addr_d = top_addr & ~AXI_ADDR_WIDTH'(BEAT_BYTES - 1);
                    shadow_len_d  = top_len;
                end
                if (start) begin
                    if (shadow_len_q == '0) begin
                        state_d = FIN;
                    end else begin
                        cur_addr_d  = shadow_addr_q;
                        remaining_d = shadow_len_q;
                        req_valid_d = 1'b1;
                        req_addr_d  = shadow_addr_q;
                        req_len_d   = 8'(calc_beats - 9'd1);
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (accept) begin
                    // One idle cycle after each acceptance lets the sizer see
                    // the advanced address before the next request is built.
                    req_valid_d = 1'b0;
                    cur_addr_d  = cur_addr_q + (AXI_ADDR_WIDTH'(beats_issued) << BEAT_SHIFT);
                    remaining_d = remaining_q - TOP_LEN_WIDTH'(beats_issued);
                    if (remaining_d == '0) begin
                        state_d = DRAIN;
                    end
                end else if (!req_valid_q && (outstanding_d < OUT_W'(MAX_OUTSTANDING))) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = cur_addr_q;
                    req_len_d   = 8'(calc_beats - 9'd1);
                end
            end
            DRAIN: begin
                if (outstanding_d == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
        done_d = (state_q == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shadow_addr_q <= '0;
            shadow_len_q  <= '0;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_len_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_addr_q <= shadow_addr_d;
            shadow_len_q  <= shadow_len_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_len_q     <= req_len_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign req_if.req_valid = req_valid_q;
    assign req_if.req_addr  = req_addr_q;
    assign req_if.req_len   = req_len_q;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule

// File: tb/tb_fft_dma_burst_scheduler.sv
// Scoreboard bench for fft_dma_burst_scheduler: expected burst requests are
// queued when a transfer is started and popped as the DUT's requests are
// accepted; an optional responder returns burst_done 5 cycles after accept.
module tb_fft_dma_burst_scheduler;
    import fft_dma_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        top_valid;
    logic [31:0] top_addr;
    logic [31:0] top_len;
    logic        start;
    logic        dut_busy;
    logic        dut_done;

    fft_dma_burst_scheduler_if #(.AXI_ADDR_WIDTH(32)) bus ();

    fft_dma_burst_scheduler #(
        .AXI_ADDR_WIDTH  (32),
        .TOP_LEN_WIDTH   (32),
        .BEAT_BYTES      (8),
        .MAX_BURST       (256),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .top_valid (top_valid),
        .top_addr  (top_addr),
        .top_len   (top_len),
        .start     (start),
        .req_if    (bus.master),
        .busy      (dut_busy),
        .done      (dut_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    dma_burst_req_t exp_q[$];
    int             due_q[$];
    int             cyc         = 0;
    int             last_bd_cyc = 0;
    int             done_cnt    = 0;
    int             done_cyc    = 0;
    int             acc_cnt     = 0;
    int             valid_seen  = 0;
    int             busy_seen   = 0;
    logic           auto_done   = 1'b0;

    function automatic void push_req(input logic [31:0] a, input logic [7:0] l);
        dma_burst_req_t r;
        r.addr = a;
        r.len  = l;
        exp_q.push_back(r);
    endfunction

    // Reference split: min(remaining, 256, beats to next 4 KB boundary)
    function automatic void push_split(input logic [31:0] a_in, input int unsigned len);
        logic [31:0] a;
        int unsigned r, b, bnd;
        a = a_in & 32'hFFFF_FFF8;
        r = len;
        while (r != 0) begin
            b   = (r > 256) ? 256 : r;
            bnd = (4096 - int'(a[11:0])) / 8;
            if (b > bnd) b = bnd;
            push_req(a, 8'(b - 1));
            a = a + 32'(b * 8);
            r = r - b;
        end
    endfunction

    // Responder: counts cycles and returns completions when enabled
    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        if (auto_done) begin
            if (due_q.size() != 0 && due_q[0] == cyc) begin
                bus.burst_done = 1'b1;
                last_bd_cyc    = cyc;
                void'(due_q.pop_front());
            end else begin
                bus.burst_done = 1'b0;
            end
        end
    end

    // Monitor: sampled mid-cycle; a valid&&ready seen here is accepted at the next edge
    always @(negedge clk) begin
        dma_burst_req_t e;
        if (rst_n) begin
            if (bus.req_valid) valid_seen++;
            if (dut_busy) busy_seen++;
            if (dut_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.req_valid && bus.req_ready) begin
                acc_cnt++;
                if (auto_done) due_q.push_back(cyc + 6);
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 64'(bus.req_addr), 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("req_addr", 64'(bus.req_addr), 64'(e.addr));
                    check("req_len", 64'(bus.req_len), 64'(e.len));
                end
            end
        end
    end

    task automatic load_start(input logic [31:0] a, input logic [31:0] l, output int s);
        @(posedge clk); #2;
        top_valid = 1'b1; top_addr = a; top_len = l;
        @(posedge clk); #2;
        top_valid = 1'b0; start = 1'b1; s = cyc;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n0);
        int t = 0;
        while (done_cnt == n0 && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        repeat (4) @(negedge clk);
        #1;
        check(tag, 64'(done_cnt - n0), 64'd1);
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int s, n0, a0, t;
        logic [31:0] ra;
        logic [7:0]  rl;

        rst_n = 1'b0; top_valid = 1'b0; top_addr = '0; top_len = '0; start = 1'b0;
        bus.req_ready = 1'b0; bus.burst_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_valid", 64'(bus.req_valid), 64'd0);
        check("rst_req_addr", 64'(bus.req_addr), 64'd0);
        check("rst_req_len", 64'(bus.req_len), 64'd0);
        check("rst_busy", 64'(dut_busy), 64'd0);
        check("rst_done", 64'(dut_done), 64'd0);
        @(posedge clk); #2; rst_n = 1'b1;

        // Normal split
        auto_done = 1'b1; bus.req_ready = 1'b1;
        push_req(32'h1000, 8'd255); push_req(32'h1800, 8'd255); push_req(32'h2000, 8'd87);
        n0 = done_cnt;
        load_start(32'h1000, 32'd600, s);
        wait_done("normal_done", n0);
        check("normal_done_timing", 64'(done_cyc), 64'(last_bd_cyc + 2));

        // 4 KB crossing
        push_req(32'h0F00, 8'd31); push_req(32'h1000, 8'd31);
        n0 = done_cnt;
        load_start(32'h0F00, 32'd64, s);
        wait_done("cross4k_done", n0);

        // Zero length
        n0 = done_cnt; valid_seen = 0; busy_seen = 0;
        load_start(32'h4000, 32'd0, s);
        wait_done("zero_done", n0);
        check("zero_done_cycle", 64'(done_cyc), 64'(s + 2));
        check("zero_no_valid", 64'(valid_seen), 64'd0);
        check("zero_no_busy", 64'(busy_seen), 64'd0);

        // Outstanding limit, completions supplied by hand
        auto_done = 1'b0; bus.req_ready = 1'b1;
        push_split(32'h0, 2048);
        n0 = done_cnt; a0 = acc_cnt;
        load_start(32'h0, 32'd2048, s);
        repeat (20) @(negedge clk);
        check("limit_accepts", 64'(acc_cnt - a0), 64'd4);
        check("limit_valid_low", 64'(bus.req_valid), 64'd0);
        @(posedge clk); #2; bus.req_ready = 1'b0; bus.burst_done = 1'b1;
        @(posedge clk); #2; bus.burst_done = 1'b0;
        @(negedge clk);
        check("limit_reassert", 64'(bus.req_valid), 64'd1);
        @(posedge clk); #2; bus.req_ready = 1'b1; bus.burst_done = 1'b1;
        @(posedge clk); #2; bus.burst_done = 1'b0;
        @(negedge clk);
        check("simul_gap", 64'(bus.req_valid), 64'd0);
        @(negedge clk);
        check("simul_count_kept", 64'(bus.req_valid), 64'd1);
        repeat (6) @(negedge clk);
        check("limit_again_low", 64'(bus.req_valid), 64'd0);
        check("limit_total_acc", 64'(acc_cnt - a0), 64'd6);
        @(posedge clk); #2; bus.burst_done = 1'b1;
        t = 0;
        while (done_cnt == n0 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        @(posedge clk); #2; bus.burst_done = 1'b0;
        check("limit_done", 64'(done_cnt - n0), 64'd1);
        check("limit_sb_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure and ignored inputs
        auto_done = 1'b1; bus.req_ready = 1'b0;
        push_split(32'h3000, 300);
        n0 = done_cnt;
        load_start(32'h3000, 32'd300, s);
        t = 0;
        while (!bus.req_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_up", 64'(bus.req_valid), 64'd1);
        ra = bus.req_addr; rl = bus.req_len;
        check("bp_first_addr", 64'(ra), 64'h3000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            start     = (i == 3);
            top_valid = (i == 5);
            top_addr  = 32'h8000;
            top_len   = 32'd5;
            @(negedge clk);
            check("bp_addr_stable", 64'(bus.req_addr), 64'(ra));
            check("bp_len_stable", 64'(bus.req_len), 64'(rl));
            check("bp_valid_held", 64'(bus.req_valid), 64'd1);
        end
        @(posedge clk); #2; start = 1'b0; top_valid = 1'b0; bus.req_ready = 1'b1;
        wait_done("bp_done", n0);
        // Shadow must still hold 0x3000/300: restart without reloading
        push_split(32'h3000, 300);
        n0 = done_cnt;
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        wait_done("bp_shadow_kept", n0);

        // Reset mid-transfer
        auto_done = 1'b0; bus.req_ready = 1'b1;
        push_split(32'h5000, 2048);
        n0 = done_cnt; a0 = acc_cnt;
        load_start(32'h5000, 32'd2048, s);
        t = 0;
        while ((acc_cnt - a0) < 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rstmid_two_acc", 64'(acc_cnt - a0), 64'd2);
        @(posedge clk); #2; rst_n = 1'b0;
        #1;
        check("rstmid_valid", 64'(bus.req_valid), 64'd0);
        check("rstmid_addr", 64'(bus.req_addr), 64'd0);
        check("rstmid_len", 64'(bus.req_len), 64'd0);
        check("rstmid_busy", 64'(dut_busy), 64'd0);
        check("rstmid_done", 64'(dut_done), 64'd0);
        exp_q.delete(); due_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_no_done", 64'(done_cnt - n0), 64'd0);
        auto_done = 1'b1;
        push_req(32'h6000, 8'd7);
        a0 = acc_cnt;
        load_start(32'h6000, 32'd8, s);
        wait_done("rstmid_after_done", n0);
        check("rstmid_after_acc", 64'(acc_cnt - a0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
